vector_abs_pipe: RTL and testbench

Pipelined, parametrised successor of the combinational vector-magnitude estimator. Computes the alpha-max-plus-beta-min approximation |(x, y)| ≈ max + beta·min over a valid/ready stream, with selectable beta, optional two's-complement inputs and an overflow-free widened result. It sits between a streaming coordinate source and any consumer that needs a cheap 2-D vector length, and sustains one result per clock under back-pressure.

---
 rtl/vector_abs_pipe.sv | 102 ++++++++++
 tb/tb_vector_abs_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_abs_pipe.sv
// Two-stage streaming estimate of a 2-D vector length: |(x, y)| ~= max + beta*min.
// Stage 1 registers the sorted magnitudes and beta select, stage 2 registers the widened sum.
module vector_abs_pipe #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   abs_o
);

    // A negative two's-complement value is negated in WIDTH unsigned bits.
    // The most negative value maps to 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1]) begin
            return (~v) + WIDTH'(1);
        end
        return v;
    endfunction

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_max_q;
    logic [WIDTH-1:0] s1_min_q;
    logic [1:0]       s1_mode_q;
    logic             s2_valid_q;
    logic [WIDTH:0]   s2_abs_q;

    logic             s1_adv;
    logic             s2_adv;
    logic             in_fire;
    logic [WIDTH-1:0] mag_x;
    logic [WIDTH-1:0] mag_y;
    logic             swap;
    logic [WIDTH-1:0] term;
    logic [WIDTH:0]   sum;

    // Handshake: a beat transfers on a rising edge where valid and ready are both high on
    // that side. ready_o depends only on pipeline state and ready_i, never on valid_i, and
    // a presented result (valid_o with abs_o) stays unchanged until the consumer takes it.
    assign s2_adv  = !s2_valid_q || ready_i;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign ready_o = s1_adv;
    assign in_fire = valid_i && s1_adv;

    assign mag_x = magnitude(x_i);
    assign mag_y = magnitude(y_i);
    assign swap  = (mag_x < mag_y);

    // Each shift is floored on its own so mode 2 matches (min>>2)+(min>>3) exactly.
    always_comb begin
        term = '0;
        case (s1_mode_q)
            2'd0:    term = s1_min_q >> 1;
            2'd1:    term = s1_min_q >> 2;
            2'd2:    term = (s1_min_q >> 2) + (s1_min_q >> 3);
            default: term = '0;
        endcase
    end

    assign sum = {1'b0, s1_max_q} + {1'b0, term};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_max_q   <= '0;
            s1_min_q   <= '0;
            s1_mode_q  <= 2'd0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= valid_i;
            end
            if (in_fire) begin
                s1_max_q  <= swap ? mag_y : mag_x;
                s1_min_q  <= swap ? mag_x : mag_y;
                s1_mode_q <= mode_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_abs_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_abs_q <= sum;
            end
        end
    end

    assign valid_o = s2_valid_q;
    assign abs_o   = s2_abs_q;

endmodule

// File: tb/tb_vector_abs_pipe.sv
// Directed and randomised checks of vector_abs_pipe in three configurations:
// A = 32-bit unsigned, B = 8-bit unsigned, C = 8-bit signed.
module tb_vector_abs_pipe;

    logic clk;
    logic rst_n;

    logic        a_valid, a_ready_o, a_valid_o, a_ready;
    logic [31:0] a_x, a_y;
    logic [1:0]  a_mode;
    logic [32:0] a_abs;

    logic        b_valid, b_ready_o, b_valid_o, b_ready;
    logic [7:0]  b_x, b_y;
    logic [1:0]  b_mode;
    logic [8:0]  b_abs;

    logic        c_valid, c_ready_o, c_valid_o, c_ready;
    logic [7:0]  c_x, c_y;
    logic [1:0]  c_mode;
    logic [8:0]  c_abs;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] exp_q[$];

    vector_abs_pipe #(.WIDTH(32), .SIGNED(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .ready_o(a_ready_o),
        .x_i(a_x), .y_i(a_y), .mode_i(a_mode), .valid_o(a_valid_o),
        .ready_i(a_ready), .abs_o(a_abs)
    );

    vector_abs_pipe #(.WIDTH(8), .SIGNED(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .ready_o(b_ready_o),
        .x_i(b_x), .y_i(b_y), .mode_i(b_mode), .valid_o(b_valid_o),
        .ready_i(b_ready), .abs_o(b_abs)
    );

    vector_abs_pipe #(.WIDTH(8), .SIGNED(1'b1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(c_valid), .ready_o(c_ready_o),
        .x_i(c_x), .y_i(c_y), .mode_i(c_mode), .valid_o(c_valid_o),
        .ready_i(c_ready), .abs_o(c_abs)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_send(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        a_valid = 1'b1;
        a_x     = x;
        a_y     = y;
        a_mode  = m;
        tick();
    endtask

    task automatic b_send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
        b_valid = 1'b1;
        b_x     = x;
        b_y     = y;
        b_mode  = m;
        tick();
    endtask

    task automatic c_send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
        c_valid = 1'b1;
        c_x     = x;
        c_y     = y;
        c_mode  = m;
        tick();
    endtask

    // Reference for the 8-bit signed configuration, in plain integer arithmetic.
    function automatic logic [8:0] model_c(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] m);
        int ix, iy, hi, lo, t;
        ix = $signed(x);
        iy = $signed(y);
        if (ix < 0) ix = -ix;
        if (iy < 0) iy = -iy;
        hi = (ix > iy) ? ix : iy;
        lo = (ix > iy) ? iy : ix;
        case (m)
            2'd0:    t = lo / 2;
            2'd1:    t = lo / 4;
            2'd2:    t = lo / 4 + lo / 8;
            default: t = 0;
        endcase
        return 9'(hi + t);
    endfunction

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        int accepted;
        int cycles;
        logic in_fire, out_fire, hold;
        logic [8:0] hold_abs;
        logic [8:0] exp_v;

        a_valid = 0; a_x = '0; a_y = '0; a_mode = '0; a_ready = 1;
        b_valid = 0; b_x = '0; b_y = '0; b_mode = '0; b_ready = 1;
        c_valid = 0; c_x = '0; c_y = '0; c_mode = '0; c_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_a_valid_o", a_valid_o, 0);
        check("rst_a_abs", a_abs, 0);
        check("rst_a_ready_o", a_ready_o, 1);
        check("rst_b_valid_o", b_valid_o, 0);
        check("rst_c_valid_o", c_valid_o, 0);
        tick();
        tick();
        #2 rst_n = 1'b1;

        // Basic results, one per cycle, each on the cycle after acceptance.
        a_send(32'd0, 32'd0, 2'd0);
        check("basic_first_latency", a_valid_o, 0);
        a_send(32'd1, 32'd1, 2'd0);
        check("basic_0_0_valid", a_valid_o, 1);
        check("basic_0_0", a_abs, 0);
        a_send(32'd3, 32'd4, 2'd0);
        check("basic_1_1", a_abs, 1);
        a_send(32'd4, 32'd3, 2'd0);
        check("basic_3_4", a_abs, 5);
        a_send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0);
        check("basic_4_3", a_abs, 5);
        a_send(32'hFFFF_FFFF, 32'd7, 2'd2);
        check("ovf_all_ones", a_abs, 33'h1_7FFF_FFFE);
        a_valid = 1'b0;
        tick();
        check("ovf_mode2_min7", a_abs, 33'h1_0000_0000);
        tick();
        check("basic_drained", a_valid_o, 0);

        // Beta select follows each beat.
        b_send(8'd100, 8'd80, 2'd0);
        b_send(8'd100, 8'd80, 2'd1);
        check("mode0", b_abs, 140);
        b_send(8'd100, 8'd80, 2'd2);
        check("mode1", b_abs, 120);
        b_send(8'd100, 8'd80, 2'd3);
        check("mode2", b_abs, 130);
        b_valid = 1'b0;
        tick();
        check("mode3", b_abs, 100);

        // Signed magnitudes, including the most negative value.
        c_send(8'h80, 8'hFD, 2'd0);
        c_send(8'hFB, 8'd12, 2'd0);
        check("signed_m128_m3", c_abs, 9'h081);
        c_valid = 1'b0;
        tick();
        check("signed_m5_12", c_abs, 14);
        tick();

        // Back-pressure: two beats fill the pipe, the third waits.
        a_ready = 1'b0;
        a_send(32'd3, 32'd4, 2'd0);
        check("bp_ready_after_one", a_ready_o, 1);
        a_send(32'd6, 32'd8, 2'd0);
        a_x = 32'd5; a_y = 32'd12; a_mode = 2'd1;
        check("bp_full_ready", a_ready_o, 0);
        check("bp_full_valid", a_valid_o, 1);
        check("bp_full_abs_A", a_abs, 5);
        tick();
        check("bp_hold_ready", a_ready_o, 0);
        check("bp_hold_abs_A", a_abs, 5);
        a_ready = 1'b1;
        #1;
        check("bp_drain_accept_ready", a_ready_o, 1);
        tick();
        a_valid = 1'b0;
        check("bp_out_B", a_abs, 11);
        tick();
        check("bp_out_C", a_abs, 13);
        tick();
        check("bp_empty", a_valid_o, 0);

        // Random traffic on the signed 8-bit instance against the reference.
        accepted = 0;
        cycles   = 0;
        hold     = 1'b0;
        hold_abs = '0;
        while (accepted < 200 && cycles < 4000) begin
            c_valid = ($urandom_range(0, 3) != 0);
            c_ready = ($urandom_range(0, 2) != 0);
            c_x     = 8'($urandom_range(0, 255));
            c_y     = 8'($urandom_range(0, 255));
            c_mode  = 2'($urandom_range(0, 3));
            #1;
            if (hold) begin
                check("rand_hold_valid", c_valid_o, 1);
                check("rand_hold_abs", c_abs, hold_abs);
            end
            in_fire  = c_valid && c_ready_o;
            out_fire = c_valid_o && c_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_out", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_abs", c_abs, exp_v);
                end
            end
            if (in_fire) begin
                exp_q.push_back(model_c(c_x, c_y, c_mode));
                accepted++;
            end
            hold     = c_valid_o && !c_ready;
            hold_abs = c_abs;
            tick();
            cycles++;
        end
        check("rand_accept_budget", accepted, 200);
        c_valid = 1'b0;
        c_ready = 1'b1;
        cycles  = 0;
        while (exp_q.size() != 0 && cycles < 20) begin
            if (c_valid_o) begin
                exp_v = exp_q.pop_front();
                check("rand_drain_abs", c_abs, exp_v);
            end
            tick();
            cycles++;
        end
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_no_extra", c_valid_o, 0);

        // Reset mid-stream with two beats in flight.
        a_ready = 1'b0;
        a_send(32'd3, 32'd4, 2'd0);
        a_send(32'd6, 32'd8, 2'd0);
        a_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid_o", a_valid_o, 0);
        check("midrst_abs", a_abs, 0);
        check("midrst_ready_o", a_ready_o, 1);
        tick();
        #2 rst_n = 1'b1;
        a_ready = 1'b1;
        a_send(32'd3, 32'd4, 2'd0);
        a_valid = 1'b0;
        check("midrst_no_stale", a_valid_o, 0);
        tick();
        check("midrst_new_valid", a_valid_o, 1);
        check("midrst_new_abs", a_abs, 5);
        tick();
        check("midrst_done", a_valid_o, 0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
